// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO hub: internal block tags, error
// status bit positions, internal register offsets and the decode result.
package mmio_pkg;

  localparam logic [11:0] ERR_TAG_DEF = 12'hFFE;
  localparam logic [11:0] TMR_TAG_DEF = 12'hFFD;

  localparam int ERR_RD_UNMAP = 0;
  localparam int ERR_WR_UNMAP = 1;
  localparam int ERR_COLLIDE  = 2;
  localparam int ERR_RO       = 3;

  localparam logic [19:0] OFF_ERR_STATUS = 20'h00000;
  localparam logic [19:0] OFF_ERR_ADDR   = 20'h00004;

  localparam logic [19:0] OFF_TMR_US  = 20'h00000;
  localparam logic [19:0] OFF_TMR_MS  = 20'h00004;
  localparam logic [19:0] OFF_TMR_S   = 20'h00008;
  localparam logic [19:0] OFF_TMR_CYC = 20'h0000C;
  localparam logic [19:0] OFF_TMR_CLR = 20'h00010;

  // Sub-counter terminal value: 1000 us per ms, 1000 ms per s.
  localparam int unsigned SUB_MAX = 999;

  typedef enum logic [1:0] {
    SLV,
    ERR,
    TMR,
    NONE
  } dec_kind_e;

  typedef struct packed {
    dec_kind_e  kind;
    logic [3:0] idx;
  } dec_t;

endpackage

// File: rtl/mmio_timebase.sv
// Free-running timebase: raw cycle count plus us/ms/s counters derived from
// CLK_HZ. A synchronous clear zeroes every counter and prescaler.
module mmio_timebase
  import mmio_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  output logic [31:0] us,
  output logic [31:0] ms,
  output logic [31:0] s,
  output logic [31:0] cycles
);

  localparam int unsigned PRE_MAX = CLK_HZ / 1_000_000 - 1;
  localparam int          PW      = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_MAX);
  localparam logic [9:0]    SUB_LAST = 10'(SUB_MAX);

  logic [PW-1:0] pre;
  logic [9:0]    us_sub;
  logic [9:0]    ms_sub;

  // Prescaler wraps once per microsecond; us/ms sub-counters cascade upward.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre    <= '0;
      us_sub <= '0;
      ms_sub <= '0;
      us     <= '0;
      ms     <= '0;
      s      <= '0;
      cycles <= '0;
    end else if (clr) begin
      pre    <= '0;
      us_sub <= '0;
      ms_sub <= '0;
      us     <= '0;
      ms     <= '0;
      s      <= '0;
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (pre == PRE_LAST) begin
        pre <= '0;
        us  <= us + 32'd1;
        if (us_sub == SUB_LAST) begin
          us_sub <= '0;
          ms     <= ms + 32'd1;
          if (ms_sub == SUB_LAST) begin
            ms_sub <= '0;
            s      <= s + 32'd1;
          end else begin
            ms_sub <= ms_sub + 10'd1;
          end
        end else begin
          us_sub <= us_sub + 10'd1;
        end
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_hub.sv
// MMIO interconnect: decodes addr[31:20] to N_SLV external channels or the
// internal error/timebase blocks, returns read data one cycle later, and
// keeps sticky error status with the address of the first error.
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int                  N_SLV       = 4,
  // Entry i (channel i) lives at bits [(N_SLV-1-i)*12 +: 12], so the
  // leftmost tag in the concatenation belongs to channel 0.
  parameter logic [N_SLV*12-1:0] SLV_TAGS    = {12'h001, 12'h002, 12'h003, 12'h004},
  parameter logic [11:0]         ERR_TAG     = ERR_TAG_DEF,
  parameter logic [11:0]         TMR_TAG     = TMR_TAG_DEF,
  parameter int unsigned         CLK_HZ      = 50_000_000,
  parameter logic [31:0]         UNMAP_RDATA = 32'h0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic                  we,
  input  logic                  re,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  output logic [N_SLV-1:0]      slv_sel,
  output logic                  slv_we,
  output logic [19:0]           slv_addr,
  output logic [31:0]           slv_wdata,
  input  logic [N_SLV*32-1:0]   slv_rdata,
  output logic                  err_irq
);

  logic [11:0] tag;
  logic [19:0] off;
  dec_t        dec;
  logic [31:0] slv_word;
  logic [31:0] rd_next;
  logic [3:0]  err_status;
  logic [31:0] err_addr;
  logic [3:0]  err_new;
  logic [3:0]  w1c;
  logic [3:0]  err_kept;
  logic        ro_hit;
  logic        tmr_clr;
  logic [31:0] tmr_us;
  logic [31:0] tmr_ms;
  logic [31:0] tmr_s;
  logic [31:0] tmr_cyc;

  assign tag       = addr[31:20];
  assign off       = addr[19:0];
  assign slv_addr  = addr[19:0];
  assign slv_wdata = wdata;
  assign slv_we    = we & (|slv_sel);
  assign err_irq   = |err_status;

  // Address decode: internal blocks first, then lowest-index channel tag.
  always_comb begin
    dec.kind = NONE;
    dec.idx  = '0;
    if (tag == ERR_TAG) begin
      dec.kind = ERR;
    end else if (tag == TMR_TAG) begin
      dec.kind = TMR;
    end else begin
      for (int i = N_SLV - 1; i >= 0; i--) begin
        if (SLV_TAGS[(N_SLV-1-i)*12 +: 12] == tag) begin
          dec.kind = SLV;
          dec.idx  = 4'(i);
        end
      end
    end
  end

  // One-hot channel select and the selected channel's read word.
  always_comb begin
    slv_sel  = '0;
    slv_word = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (dec.kind == SLV && dec.idx == 4'(i)) begin
        slv_sel[i] = re | we;
        slv_word   = slv_rdata[i*32 +: 32];
      end
    end
  end

  // Read source mux; a colliding read is answered with the unmapped value.
  always_comb begin
    rd_next = UNMAP_RDATA;
    if (!(re && we)) begin
      case (dec.kind)
        SLV: rd_next = slv_word;
        ERR: begin
          case (off)
            OFF_ERR_STATUS: rd_next = {28'd0, err_status};
            OFF_ERR_ADDR:   rd_next = err_addr;
            default:        rd_next = 32'd0;
          endcase
        end
        TMR: begin
          case (off)
            OFF_TMR_US:  rd_next = tmr_us;
            OFF_TMR_MS:  rd_next = tmr_ms;
            OFF_TMR_S:   rd_next = tmr_s;
            OFF_TMR_CYC: rd_next = tmr_cyc;
            default:     rd_next = 32'd0;
          endcase
        end
        default: rd_next = UNMAP_RDATA;
      endcase
    end
  end

  // Error events this cycle, W1C mask, and status surviving the clear.
  always_comb begin
    ro_hit = 1'b0;
    if (dec.kind == TMR) begin
      ro_hit = (off == OFF_TMR_US) || (off == OFF_TMR_MS) ||
               (off == OFF_TMR_S)  || (off == OFF_TMR_CYC);
    end else if (dec.kind == ERR) begin
      ro_hit = (off == OFF_ERR_ADDR);
    end
    err_new               = '0;
    err_new[ERR_RD_UNMAP] = re & ~we & (dec.kind == NONE);
    err_new[ERR_WR_UNMAP] = we & (dec.kind == NONE);
    err_new[ERR_COLLIDE]  = re & we;
    err_new[ERR_RO]       = we & ro_hit;
    w1c      = (we && dec.kind == ERR && off == OFF_ERR_STATUS) ? wdata[3:0] : 4'd0;
    err_kept = err_status & ~w1c;
  end

  assign tmr_clr = we && (dec.kind == TMR) && (off == OFF_TMR_CLR);

  // Registered read response, one cycle after the request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        rdata <= rd_next;
      end
    end
  end

  // Sticky status; new errors beat a same-cycle clear. The address is
  // captured only when status is (or is being cleared to) zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_status <= '0;
      err_addr   <= '0;
    end else begin
      err_status <= err_kept | err_new;
      if ((err_new != 4'd0) && (err_kept == 4'd0)) begin
        err_addr <= addr;
      end
    end
  end

  mmio_timebase #(
    .CLK_HZ(CLK_HZ)
  ) u_timebase (
    .clock (clock),
    .reset (reset),
    .clr   (tmr_clr),
    .us    (tmr_us),
    .ms    (tmr_ms),
    .s     (tmr_s),
    .cycles(tmr_cyc)
  );

endmodule
